// File: rtl/physics_pkg.sv
// physics_pkg: shared widths, types and saturation helper
// for the soft-body physics step controller.
package physics_pkg;

  localparam int POS_W = 8;
  localparam int VEL_W = 8;
  localparam int FRC_W = 8;

  typedef logic signed [POS_W-1:0] pos_t;
  typedef logic signed [VEL_W-1:0] vel_t;
  typedef logic signed [FRC_W-1:0] force_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    INTEG,
    DONE
  } state_t;

  // Add two values and clamp to an n-bit signed range.
  function automatic logic signed [31:0] sat_add(
    input logic signed [31:0] a,
    input logic signed [31:0] b,
    input int                 n
  );
    logic signed [31:0] s;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    s  = a + b;
    hi = (32'sd1 <<< (n - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/node_integrator.sv
// node_integrator: one semi-implicit Euler update for a
// single node (velocity first, then position).
module node_integrator
  import physics_pkg::*;
#(
  parameter int P       = POS_W,
  parameter int V       = VEL_W,
  parameter int F       = FRC_W,
  parameter int SHIFT   = 2,
  parameter int GRAVITY = -1
) (
  input  logic [1:0][P-1:0] p_i,
  input  logic [1:0][V-1:0] v_i,
  input  logic [1:0][F-1:0] f_i,
  output logic [1:0][P-1:0] p_o,
  output logic [1:0][V-1:0] v_o
);

  logic signed [31:0] fx;
  logic signed [31:0] fy;
  logic signed [31:0] vx;
  logic signed [31:0] vy;

  // Arithmetic shift rounds toward minus infinity.
  assign fx = 32'($signed(f_i[0])) >>> SHIFT;
  assign fy = 32'($signed(f_i[1])) >>> SHIFT;

  assign vx = sat_add(32'($signed(v_i[0])), fx, V);
  assign vy = sat_add(32'($signed(v_i[1])) + fy,
                      GRAVITY, V);

  assign v_o[0] = V'(vx);
  assign v_o[1] = V'(vy);

  assign p_o[0] = P'(sat_add(32'($signed(p_i[0])), vx, P));
  assign p_o[1] = P'(sat_add(32'($signed(p_i[1])), vy, P));

endmodule

// File: rtl/spring_step_ctrl.sv
// spring_step_ctrl: sequences one physics step around the
// springs datapath and owns the node state registers.
module spring_step_ctrl
  import physics_pkg::*;
#(
  parameter int NUM_NODES      = 3,
  parameter int POSITION_SIZE  = POS_W,
  parameter int VELOCITY_SIZE  = VEL_W,
  parameter int FORCE_SIZE     = FRC_W,
  parameter int FORCE_SHIFT    = 2,
  parameter int GRAVITY        = -1,
  parameter int TIMEOUT_CYCLES = 1023,
  localparam int IW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic step_in,
  input  logic load_valid,
  input  logic [IW-1:0] load_idx,
  input  logic [1:0][POSITION_SIZE-1:0] load_pos,
  input  logic [1:0][VELOCITY_SIZE-1:0] load_vel,
  output logic springs_start,
  input  logic springs_done,
  input  logic [1:0][NUM_NODES-1:0][FORCE_SIZE-1:0] spring_forces,
  output logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0] nodes,
  output logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0] velocities,
  output logic busy,
  output logic step_done,
  output logic timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0] pos_arr_t;
  typedef logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0] vel_arr_t;
  typedef logic [1:0][NUM_NODES-1:0][FORCE_SIZE-1:0] frc_arr_t;

  state_t state_q, state_d;
  pos_arr_t pos_q, pos_d;
  vel_arr_t vel_q, vel_d;
  frc_arr_t frc_q, frc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic pend_q, pend_d;
  logic terr_q, terr_d;

  logic [1:0][POSITION_SIZE-1:0] cur_p, new_p;
  logic [1:0][VELOCITY_SIZE-1:0] cur_v, new_v;
  logic [1:0][FORCE_SIZE-1:0] cur_f;

  // Single shared integrator, fed by the node selected by idx_q.
  always_comb begin
    for (int a = 0; a < 2; a++) begin
      cur_p[a] = pos_q[a][idx_q];
      cur_v[a] = vel_q[a][idx_q];
      cur_f[a] = frc_q[a][idx_q];
    end
  end

  node_integrator #(
    .P       (POSITION_SIZE),
    .V       (VELOCITY_SIZE),
    .F       (FORCE_SIZE),
    .SHIFT   (FORCE_SHIFT),
    .GRAVITY (GRAVITY)
  ) u_integ (
    .p_i (cur_p),
    .v_i (cur_v),
    .f_i (cur_f),
    .p_o (new_p),
    .v_o (new_v)
  );

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    vel_d   = vel_q;
    frc_d   = frc_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    terr_d  = terr_q;
    pend_d  = pend_q | (step_in && (state_q != IDLE));
    unique case (state_q)
      IDLE: begin
        if (load_valid && (32'(load_idx) < NUM_NODES)) begin
          for (int a = 0; a < 2; a++) begin
            pos_d[a][load_idx] = load_pos[a];
            vel_d[a][load_idx] = load_vel[a];
          end
        end
        if (step_in || pend_q) begin
          state_d = START;
          pend_d  = 1'b0;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (springs_done) begin
          frc_d   = spring_forces;
          idx_d   = '0;
          state_d = INTEG;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          terr_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      INTEG: begin
        for (int a = 0; a < 2; a++) begin
          pos_d[a][idx_q] = new_p[a];
          vel_d[a][idx_q] = new_v[a];
        end
        if (idx_q == IW'(NUM_NODES - 1)) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      pos_q   <= '0;
      vel_q   <= '0;
      frc_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      vel_q   <= vel_d;
      frc_q   <= frc_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      terr_q  <= terr_d;
    end
  end

  assign springs_start = (state_q == START);
  assign step_done     = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign timeout_err   = terr_q;
  assign nodes         = pos_q;
  assign velocities    = vel_q;

endmodule
